// File: rtl/enc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : enc_pkg
//  Description : Shared definitions for the Hamming encoder pipeline: the
//                work-mode enum, per-mode info/parity/pad widths, and the
//                H-row masks (one 32-bit mask per parity row, over codeword
//                bit positions) shared with the overall-parity stage.
//  Revision    : 1.0 - initial release
// ============================================================================
package enc_pkg;

    typedef enum logic [1:0] {
        MODE_8_4     = 2'b00,
        MODE_16_11   = 2'b01,
        MODE_32_26   = 2'b10,
        MODE_ILLEGAL = 2'b11
    } enc_mode_e;

    localparam int c_cw_w       = 32;
    localparam int c_info_w     = 26;

    // K = info bits, P = parity bits incl. overall slot, pad = zero bits above.
    localparam int c_k_8_4      = 4;
    localparam int c_p_8_4      = 4;
    localparam int c_pad_8_4    = 24;
    localparam int c_k_16_11    = 11;
    localparam int c_p_16_11    = 5;
    localparam int c_pad_16_11  = 16;
    localparam int c_k_32_26    = 26;
    localparam int c_p_32_26    = 6;
    localparam int c_pad_32_26  = 0;

    // H columns for the info positions run downward from the top info bit,
    // taking the non-power-of-two column values in descending order. Row 1
    // (index 0) is the MSB of the column value and drives codeword bit P-2.
    // Masks cover info positions only; parity slots are zero when masked.
    localparam logic [0:2][31:0] c_h_8_4 = {
        32'h0000_00E0, 32'h0000_00D0, 32'h0000_00B0
    };
    localparam logic [0:3][31:0] c_h_16_11 = {
        32'h0000_FE00, 32'h0000_F1C0, 32'h0000_CDA0, 32'h0000_AB60
    };
    localparam logic [0:4][31:0] c_h_32_26 = {
        32'hFFFE_0000, 32'hFF01_FC00, 32'hF0F1_E380,
        32'hCCCD_9B40, 32'hAAAB_56C0
    };

    function automatic logic row_parity(input logic [31:0] cw,
                                        input logic [31:0] mask);
        return ^(cw & mask);
    endfunction

endpackage : enc_pkg
`default_nettype wire

// File: rtl/enc_parity_calc.sv
`default_nettype none
// ============================================================================
//  Module      : enc_parity_calc
//  Description : Combinational partial-codeword builder. Places the info
//                word above the parity field, leaves the overall-parity
//                slot (bit P-1) at zero and fills bits P-2..0 from the H
//                rows. Illegal mode yields an all-zero word.
//  Ports       : info     - info word, LSB-aligned
//                mode     - work mode (enc_mode_e encoding)
//                codeword - partial codeword
//  Revision    : 1.0 - initial release
// ============================================================================
module enc_parity_calc
    import enc_pkg::*;
#(
    parameter int MAX_CODEWORD_WIDTH = 32,
    parameter int MAX_INFO_WIDTH     = 26
) (
    input  logic [MAX_INFO_WIDTH-1:0]     info,
    input  logic [1:0]                    mode,
    output logic [MAX_CODEWORD_WIDTH-1:0] codeword
);

    logic [c_info_w-1:0] w_info;
    logic [c_cw_w-1:0]   w_placed;
    logic [c_cw_w-1:0]   w_par;

    assign w_info = c_info_w'(info);

    always_comb begin
        w_placed = '0;
        w_par    = '0;
        case (enc_mode_e'(mode))
            MODE_8_4: begin
                w_placed[c_p_8_4 +: c_k_8_4] = w_info[c_k_8_4-1:0];
                for (int r = 0; r < c_p_8_4 - 1; r++)
                    w_par[c_p_8_4-2-r] = row_parity(w_placed, c_h_8_4[r]);
            end
            MODE_16_11: begin
                w_placed[c_p_16_11 +: c_k_16_11] = w_info[c_k_16_11-1:0];
                for (int r = 0; r < c_p_16_11 - 1; r++)
                    w_par[c_p_16_11-2-r] = row_parity(w_placed, c_h_16_11[r]);
            end
            MODE_32_26: begin
                w_placed[c_p_32_26 +: c_k_32_26] = w_info[c_k_32_26-1:0];
                for (int r = 0; r < c_p_32_26 - 1; r++)
                    w_par[c_p_32_26-2-r] = row_parity(w_placed, c_h_32_26[r]);
            end
            default: begin
                w_placed = '0;
                w_par    = '0;
            end
        endcase
    end

    assign codeword = MAX_CODEWORD_WIDTH'(w_placed | w_par);

endmodule : enc_parity_calc
`default_nettype wire

// File: rtl/enc_stage_1.sv
`default_nettype none
// ============================================================================
//  Module      : enc_stage_1
//  Description : First encoder stage. Builds the partial Hamming codeword
//                (info + row parities, overall-parity slot zero) and
//                presents it through a two-entry skid buffer with a
//                registered in_ready, one cycle of latency.
//  Ports       : clk, rst (async, active-low)
//                info_in/work_mod/in_valid/in_ready  - input handshake
//                data_out/mode_out/out_valid/out_ready - output handshake
//  Revision    : 1.0 - initial release
// ============================================================================
module enc_stage_1
    import enc_pkg::*;
#(
    parameter int MAX_CODEWORD_WIDTH = 32,
    parameter int MAX_INFO_WIDTH     = 26
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [MAX_INFO_WIDTH-1:0]     info_in,
    input  logic [1:0]                    work_mod,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [MAX_CODEWORD_WIDTH-1:0] data_out,
    output logic [1:0]                    mode_out,
    output logic                          out_valid,
    input  logic                          out_ready
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } skid_state_e;

    skid_state_e                   r_state;
    skid_state_e                   w_next_state;
    logic                          r_in_ready;
    logic [MAX_CODEWORD_WIDTH-1:0] r_data;
    logic [1:0]                    r_mode;
    logic [MAX_CODEWORD_WIDTH-1:0] r_skid_data;
    logic [1:0]                    r_skid_mode;

    logic [MAX_CODEWORD_WIDTH-1:0] w_enc;
    logic                          w_accept;
    logic                          w_drain;
    logic                          w_load_out;
    logic                          w_load_skid;
    logic                          w_out_from_skid;

    enc_parity_calc #(
        .MAX_CODEWORD_WIDTH (MAX_CODEWORD_WIDTH),
        .MAX_INFO_WIDTH     (MAX_INFO_WIDTH)
    ) u_parity_calc (
        .info     (info_in),
        .mode     (work_mod),
        .codeword (w_enc)
    );

    assign w_accept = in_valid & r_in_ready;
    assign w_drain  = out_valid & out_ready;

    always_comb begin
        w_next_state    = r_state;
        w_load_out      = 1'b0;
        w_load_skid     = 1'b0;
        w_out_from_skid = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (w_accept) begin
                    w_next_state = ST_ONE;
                    w_load_out   = 1'b1;
                end
            end
            ST_ONE: begin
                if (w_accept && w_drain) begin
                    w_load_out   = 1'b1;
                end else if (w_accept) begin
                    w_next_state = ST_TWO;
                    w_load_skid  = 1'b1;
                end else if (w_drain) begin
                    w_next_state = ST_EMPTY;
                end
            end
            ST_TWO: begin
                // in_ready is low here, so only a drain can happen.
                if (w_drain) begin
                    w_next_state    = ST_ONE;
                    w_out_from_skid = 1'b1;
                end
            end
            default: w_next_state = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_EMPTY;
            r_in_ready  <= 1'b0;
            r_data      <= '0;
            r_mode      <= '0;
            r_skid_data <= '0;
            r_skid_mode <= '0;
        end else begin
            r_state    <= w_next_state;
            // Registered from next state: no out_ready -> in_ready path.
            r_in_ready <= (w_next_state != ST_TWO);
            if (w_load_out) begin
                r_data <= w_enc;
                r_mode <= work_mod;
            end else if (w_out_from_skid) begin
                r_data <= r_skid_data;
                r_mode <= r_skid_mode;
            end
            if (w_load_skid) begin
                r_skid_data <= w_enc;
                r_skid_mode <= work_mod;
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = (r_state != ST_EMPTY);
    assign data_out  = r_data;
    assign mode_out  = r_mode;

endmodule : enc_stage_1
`default_nettype wire

// File: tb/tb_enc_stage_1.sv
`default_nettype none
// ============================================================================
//  Module      : tb_enc_stage_1
//  Description : Self-checking bench for enc_stage_1. A reference encoder
//                derives H columns from the Hamming construction rule, and
//                a queue of accepted words models the buffer contents.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_enc_stage_1;

    logic        clk;
    logic        rst;
    logic [25:0] info_in;
    logic [1:0]  work_mod;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] data_out;
    logic [1:0]  mode_out;
    logic        out_valid;
    logic        out_ready;

    int n_tests = 0;
    int n_fail  = 0;
    logic armed;
    logic [33:0] q[$];

    enc_stage_1 #(
        .MAX_CODEWORD_WIDTH (32),
        .MAX_INFO_WIDTH     (26)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .info_in   (info_in),
        .work_mod  (work_mod),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_out  (data_out),
        .mode_out  (mode_out),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: info positions take H columns 2^(P-1)-1 downward, skipping
    // powers of two; row r uses column bit P-1-r and drives codeword bit P-1-r.
    function automatic logic [31:0] ref_enc(input logic [25:0] info,
                                            input logic [1:0] mode);
        int k, p, col;
        int cols[26];
        logic [31:0] cw;
        logic b;
        cw = '0;
        case (mode)
            2'd0:    begin k = 4;  p = 4; end
            2'd1:    begin k = 11; p = 5; end
            2'd2:    begin k = 26; p = 6; end
            default: return 32'h0;
        endcase
        col = (1 << (p - 1)) - 1;
        for (int i = k - 1; i >= 0; i--) begin
            while ((col & (col - 1)) == 0) col--;
            cols[i]  = col;
            cw[p+i]  = info[i];
            col--;
        end
        for (int r = 1; r < p; r++) begin
            b = 1'b0;
            for (int i = 0; i < k; i++)
                if (info[i] && cols[i][p-1-r]) b = ~b;
            cw[p-1-r] = b;
        end
        return cw;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) armed <= 1'b0;
        else      armed <= 1'b1;
    end

    // Compare process: queue holds words accepted but not yet drained.
    always @(negedge clk) begin
        if (!rst) begin
            q.delete();
            check("rst_out_valid", 64'(out_valid), 64'd0);
            check("rst_in_ready",  64'(in_ready),  64'd0);
            check("rst_data_out",  64'(data_out),  64'd0);
            check("rst_mode_out",  64'(mode_out),  64'd0);
        end else begin
            check("out_valid", 64'(out_valid), 64'(q.size() != 0));
            if (armed)
                check("in_ready", 64'(in_ready), 64'(q.size() < 2));
            if (q.size() != 0) begin
                if (out_valid) begin
                    check("data_out", 64'(data_out), 64'(q[0][31:0]));
                    check("mode_out", 64'(mode_out), 64'(q[0][33:32]));
                end
                if (out_ready) void'(q.pop_front());
            end
            if (in_valid && in_ready)
                q.push_back({work_mod, ref_enc(info_in, work_mod)});
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [25:0] info, input logic [1:0] mode);
        logic rdy;
        logic ok;
        ok       = 1'b0;
        info_in  = info;
        work_mod = mode;
        in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            rdy = in_ready;
            @(posedge clk);
            #1;
            if (rdy) begin
                ok = 1'b1;
                break;
            end
        end
        in_valid = 1'b0;
        check("send_accepted", 64'(ok), 64'd1);
    endtask

    task automatic expect_out(input string name, input logic [31:0] d,
                              input logic [1:0] m);
        check({name, "_valid"}, 64'(out_valid), 64'd1);
        check({name, "_data"},  64'(data_out),  64'(d));
        check({name, "_mode"},  64'(mode_out),  64'(m));
    endtask

    initial begin
        rst       = 1'b0;
        info_in   = '0;
        work_mod  = 2'd0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #2;
        check("reset_in_ready",  64'(in_ready),  64'd0);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_data",      64'(data_out),  64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        check("in_ready_after_release", 64'(in_ready), 64'd1);

        // Literal vectors pinning both the model and the DUT.
        check("model_B",     64'(ref_enc(26'hB, 2'd0)), 64'h0000_00B1);
        check("model_all10", 64'(ref_enc(26'h3FF_FFFF, 2'd2)), 64'hFFFF_FFDF);
        send(26'hB, 2'd0);              expect_out("m0_B",    32'h0000_00B1, 2'd0);
        send(26'hF, 2'd0);              expect_out("m0_F",    32'h0000_00F7, 2'd0);
        send(26'h0, 2'd0);              expect_out("m0_0",    32'h0000_0000, 2'd0);
        send(26'h3FF_FFF1, 2'd0);       expect_out("m0_hi",   32'h0000_0013, 2'd0);
        send(26'h3FF_FFFF, 2'd2);       expect_out("m2_ones", 32'hFFFF_FFDF, 2'd2);
        check("m2_bit5", 64'(data_out[5]), 64'd0);
        send(26'h3FF_FFFF, 2'd1);       expect_out("m1_ones", 32'h0000_FFEF, 2'd1);
        send(26'h155, 2'd3);            expect_out("m3",      32'h0000_0000, 2'd3);
        repeat (2) @(posedge clk);
        #1;

        // Backpressure: three words offered, two taken, third waits.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        info_in   = 26'h1; work_mod = 2'd0;
        @(posedge clk); #1;
        info_in   = 26'h2;
        @(posedge clk); #1;
        info_in   = 26'h3;
        repeat (3) begin
            @(posedge clk); #1;
            check("bp_in_ready", 64'(in_ready), 64'd0);
            expect_out("bp_hold", 32'h0000_0013, 2'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        expect_out("bp_second", 32'h0000_0025, 2'd0);
        check("bp_ready_back", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        expect_out("bp_third", 32'h0000_0036, 2'd0);
        @(posedge clk); #1;
        check("bp_empty", 64'(out_valid), 64'd0);

        // Mixed traffic, checked cycle by cycle by the compare process.
        for (int c = 0; c < 200; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            info_in   = 26'($urandom);
            work_mod  = 2'($urandom_range(0, 3));
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        // Reset while holding two words.
        out_ready = 1'b0;
        send(26'h7, 2'd0);
        send(26'h9, 2'd0);
        check("two_in_ready", 64'(in_ready), 64'd0);
        #1 rst = 1'b0;
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_data",      64'(data_out),  64'd0);
        check("midrst_mode",      64'(mode_out),  64'd0);
        @(posedge clk); @(posedge clk);
        #1 rst = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("post_rst_empty", 64'(out_valid), 64'd0);
        send(26'h5, 2'd0);
        expect_out("post_rst_first", 32'h0000_0055, 2'd0);
        @(posedge clk); #1;
        check("post_rst_drained", 64'(out_valid), 64'd0);
        repeat (2) @(posedge clk);
        #1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_enc_stage_1
`default_nettype wire
